// File: rtl/mmi_regbank_pkg.sv
// rtl/mmi_regbank_pkg.sv - shared types and word-map helpers for the MMI register bank
//
// Purpose: FSM state type, word-map index functions and the byte-lane
// strobe merge used by the register bank and its sub-module.
package mmi_regbank_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  function automatic int out_words(input int num_out);
    return (num_out + 3) / 4;
  endfunction

  function automatic int in_words(input int num_in);
    return (num_in + 3) / 4;
  endfunction

  function automatic int chg_idx(input int num_out, input int num_in);
    return out_words(num_out) + in_words(num_in);
  endfunction

  function automatic int irq_en_idx(input int num_out, input int num_in);
    return chg_idx(num_out, num_in) + 1;
  endfunction

  // Replace each byte of old_word whose strobe bit is set with the wdata byte.
  function automatic logic [31:0] strobe_merge(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wstrb);
    logic [31:0] merged;
    for (int b = 0; b < 4; b++) begin
      merged[b*8 +: 8] = wstrb[b] ? wdata[b*8 +: 8] : old_word[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mmi_regbank_if.sv
// rtl/mmi_regbank_if.sv - valid/ready RAM-bus interface between CPU and register bank
//
// Purpose: groups the CPU memory-mapped bus signals.
// Signals: mmi_valid (request), mmi_ready (ack), mmi_wstrb (byte strobes, 0 = read),
//          i_mmi_wdata, o_mmi_rdata, i_mmi_addr (word address, ADDR_W bits).
interface mmi_regbank_if #(
  parameter int ADDR_W = 5
);
  logic              mmi_valid;
  logic              mmi_ready;
  logic [3:0]        mmi_wstrb;
  logic [31:0]       i_mmi_wdata;
  logic [31:0]       o_mmi_rdata;
  logic [ADDR_W-1:0] i_mmi_addr;

  modport master (
    output mmi_valid, mmi_wstrb, i_mmi_wdata, i_mmi_addr,
    input  mmi_ready, o_mmi_rdata
  );

  modport slave (
    input  mmi_valid, mmi_wstrb, i_mmi_wdata, i_mmi_addr,
    output mmi_ready, o_mmi_rdata
  );
endinterface

// File: rtl/mmi_in_tracker.sv
// rtl/mmi_in_tracker.sv - input sampling, change flags and interrupt reduce
//
// Purpose: samples the coprocessor input bytes, detects per-byte changes into
// sticky write-1-to-clear flags and produces the registered level interrupt.
// Ports: clk, rst (async active-low), i_regs (raw inputs), chg_clr (W1C pulse),
//        irq_en (enable mask), in_q (sampled bytes), chg_flags, irq.
module mmi_in_tracker #(
  parameter int NUM_IN = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_IN*8-1:0] i_regs,
  input  logic [NUM_IN-1:0]   chg_clr,
  input  logic [NUM_IN-1:0]   irq_en,
  output logic [NUM_IN*8-1:0] in_q,
  output logic [NUM_IN-1:0]   chg_flags,
  output logic                irq
);

  logic [NUM_IN*8-1:0] prev_q;
  logic [NUM_IN-1:0]   chg_set;

  always_comb begin
    chg_set = '0;
    for (int j = 0; j < NUM_IN; j++) begin
      chg_set[j] = (in_q[j*8 +: 8] != prev_q[j*8 +: 8]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_q      <= '0;
      prev_q    <= '0;
      chg_flags <= '0;
      irq       <= 1'b0;
    end else begin
      in_q      <= i_regs;
      prev_q    <= in_q;
      // A change landing on the same edge as a clear keeps the flag set.
      chg_flags <= chg_set | (chg_flags & ~chg_clr);
      irq       <= |(chg_flags & irq_en);
    end
  end

endmodule

// File: rtl/mmi_regbank.sv
// rtl/mmi_regbank.sv - parametrised memory-mapped register bank (top)
//
// Purpose: byte-wide output control registers (optionally self-clearing),
// sampled input registers, change flags and a maskable interrupt behind a
// two-state valid/ready bus slave.
// Ports: clk, rst (async active-low), bus (mmi_regbank_if.slave),
//        i_regs (NUM_IN bytes in), o_regs (NUM_OUT bytes out), o_irq.
module mmi_regbank
  import mmi_regbank_pkg::*;
#(
  parameter int               NUM_OUT    = 16,
  parameter int               NUM_IN     = 16,
  parameter int               ADDR_W     = 5,
  parameter logic [NUM_OUT-1:0] PULSE_MASK = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  mmi_regbank_if.slave         bus,
  input  logic [NUM_IN*8-1:0]  i_regs,
  output logic [NUM_OUT*8-1:0] o_regs,
  output logic                 o_irq
);

  localparam int OUT_WORDS  = out_words(NUM_OUT);
  localparam int IN_WORDS   = in_words(NUM_IN);
  localparam int CHG_IDX    = chg_idx(NUM_OUT, NUM_IN);
  localparam int IRQ_EN_IDX = irq_en_idx(NUM_OUT, NUM_IN);
  localparam int OUT_BITS   = OUT_WORDS * 32;
  localparam int IN_BITS    = IN_WORDS * 32;

  state_t               state;
  logic                 ready_q;
  logic [31:0]          rdata_q;
  logic [NUM_OUT*8-1:0] out_q;
  logic [NUM_IN-1:0]    irq_en_q;
  logic [NUM_IN-1:0]    irq_en_nxt;
  logic [NUM_IN*8-1:0]  in_q;
  logic [NUM_IN-1:0]    chg_flags;
  logic [NUM_IN-1:0]    chg_clr;
  logic                 start;
  logic                 wr_en;
  logic [31:0]          rd_word;
  logic [OUT_BITS-1:0]  out_pad;
  logic [OUT_BITS-1:0]  out_nxt;
  logic [IN_BITS-1:0]   in_pad;
  logic [NUM_OUT*8-1:0] pulse_bits;

  assign start   = (state == IDLE) && bus.mmi_valid;
  assign wr_en   = start && (bus.mmi_wstrb != 4'b0000);
  assign out_pad = OUT_BITS'(out_q);
  assign in_pad  = IN_BITS'(in_q);

  assign bus.mmi_ready   = ready_q;
  assign bus.o_mmi_rdata = rdata_q;
  assign o_regs          = out_q;

  always_comb begin
    pulse_bits = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      pulse_bits[k*8 +: 8] = {8{PULSE_MASK[k]}};
    end
  end

  // Pulse bytes clear every cycle unless rewritten; padding bytes past
  // NUM_OUT are dropped when stored, so they can never hold data.
  always_comb begin
    out_nxt = OUT_BITS'(out_q & ~pulse_bits);
    for (int w = 0; w < OUT_WORDS; w++) begin
      if (wr_en && (bus.i_mmi_addr == ADDR_W'(w))) begin
        out_nxt[w*32 +: 32] = strobe_merge(out_nxt[w*32 +: 32], bus.i_mmi_wdata, bus.mmi_wstrb);
      end
    end
  end

  always_comb begin
    chg_clr    = '0;
    irq_en_nxt = irq_en_q;
    for (int j = 0; j < NUM_IN; j++) begin
      if (wr_en && bus.mmi_wstrb[j/8]) begin
        if (bus.i_mmi_addr == ADDR_W'(CHG_IDX))    chg_clr[j]    = bus.i_mmi_wdata[j];
        if (bus.i_mmi_addr == ADDR_W'(IRQ_EN_IDX)) irq_en_nxt[j] = bus.i_mmi_wdata[j];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int w = 0; w < OUT_WORDS; w++) begin
      if (bus.i_mmi_addr == ADDR_W'(w)) rd_word = out_pad[w*32 +: 32];
    end
    for (int w = 0; w < IN_WORDS; w++) begin
      if (bus.i_mmi_addr == ADDR_W'(OUT_WORDS + w)) rd_word = in_pad[w*32 +: 32];
    end
    if (bus.i_mmi_addr == ADDR_W'(CHG_IDX))    rd_word = 32'(chg_flags);
    if (bus.i_mmi_addr == ADDR_W'(IRQ_EN_IDX)) rd_word = 32'(irq_en_q);
  end

  // Read data is captured from pre-write contents on the same edge the
  // write commits, then held for the single RESP cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      out_q    <= '0;
      irq_en_q <= '0;
    end else begin
      out_q    <= out_nxt[NUM_OUT*8-1:0];
      irq_en_q <= irq_en_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            rdata_q <= rd_word;
            ready_q <= 1'b1;
            state   <= RESP;
          end
        end
        RESP: begin
          rdata_q <= '0;
          ready_q <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  mmi_in_tracker #(
    .NUM_IN (NUM_IN)
  ) u_in_tracker (
    .clk       (clk),
    .rst       (rst),
    .i_regs    (i_regs),
    .chg_clr   (chg_clr),
    .irq_en    (irq_en_q),
    .in_q      (in_q),
    .chg_flags (chg_flags),
    .irq       (o_irq)
  );

endmodule

// File: tb/tb_mmi_regbank.sv
// tb/tb_mmi_regbank.sv - directed self-checking bench for mmi_regbank
module tb_mmi_regbank;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] i_regs;
  logic [127:0] o_regs;
  logic         o_irq;
  int           n_checks = 0;
  int           n_fail = 0;
  logic [31:0]  r;
  int           lat;

  mmi_regbank_if #(.ADDR_W(5)) bus ();

  mmi_regbank #(
    .NUM_OUT    (16),
    .NUM_IN     (16),
    .ADDR_W     (5),
    .PULSE_MASK (16'h0002)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .i_regs (i_regs),
    .o_regs (o_regs),
    .o_irq  (o_irq)
  );

  always #5 clk = ~clk;

  task automatic xfer(input logic [4:0] a, input logic [3:0] s, input logic [31:0] d,
                      output logic [31:0] rd, output int cyc);
    @(negedge clk);
    bus.mmi_valid = 1'b1; bus.i_mmi_addr = a; bus.mmi_wstrb = s; bus.i_mmi_wdata = d;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!bus.mmi_ready && cyc < 8);
    rd = bus.o_mmi_rdata;
    bus.mmi_valid = 1'b0; bus.mmi_wstrb = 4'h0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (bus.mmi_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %0b exp 0", bus.mmi_ready); end
    n_checks++; if (bus.o_mmi_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", bus.o_mmi_rdata); end
    n_checks++; if (o_regs !== 128'h0) begin n_fail++; $display("FAIL reset_oregs got %h exp 0", o_regs); end
    n_checks++; if (o_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %0b exp 0", o_irq); end
    rst = 1'b1;
    for (int a = 0; a < 10; a++) begin
      xfer(5'(a), 4'h0, 32'h0, r, lat);
      n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL reset_read[%0d] got %h exp 0", a, r); end
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL reset_latency[%0d] got %0d exp 1", a, lat); end
    end
    n_checks++; if (o_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq_after got %0b exp 0", o_irq); end
  endtask

  task automatic test_partial_write();
    xfer(5'd0, 4'b0101, 32'hA5A5_1234, r, lat);
    n_checks++; if (o_regs[31:0] !== 32'h00A5_0034) begin n_fail++; $display("FAIL pw_oregs got %h exp 00a50034", o_regs[31:0]); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL pw_latency got %0d exp 1", lat); end
    @(negedge clk);
    n_checks++; if (bus.mmi_ready !== 1'b0) begin n_fail++; $display("FAIL pw_ready_drop got %0b exp 0", bus.mmi_ready); end
    xfer(5'd0, 4'h0, 32'h0, r, lat);
    n_checks++; if (r !== 32'h00A5_0034) begin n_fail++; $display("FAIL pw_readback got %h exp 00a50034", r); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.mmi_valid = 1'b1; bus.i_mmi_addr = 5'd0; bus.mmi_wstrb = 4'h0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++; if (bus.mmi_ready !== ((c % 2) == 0)) begin n_fail++; $display("FAIL b2b_ready[%0d] got %0b exp %0b", c, bus.mmi_ready, (c % 2) == 0); end
      n_checks++; if (bus.o_mmi_rdata !== (((c % 2) == 0) ? 32'h00A5_0034 : 32'h0)) begin n_fail++; $display("FAIL b2b_rdata[%0d] got %h", c, bus.o_mmi_rdata); end
    end
    bus.mmi_valid = 1'b0;
  endtask

  task automatic test_pulse();
    xfer(5'd0, 4'b0010, 32'h0000_7E00, r, lat);
    n_checks++; if (o_regs[31:0] !== 32'h00A5_7E34) begin n_fail++; $display("FAIL pulse_on got %h exp 00a57e34", o_regs[31:0]); end
    @(negedge clk);
    n_checks++; if (o_regs[31:0] !== 32'h00A5_0034) begin n_fail++; $display("FAIL pulse_off got %h exp 00a50034", o_regs[31:0]); end
    xfer(5'd0, 4'h0, 32'h0, r, lat);
    n_checks++; if (r !== 32'h00A5_0034) begin n_fail++; $display("FAIL pulse_read got %h exp 00a50034", r); end
  endtask

  task automatic test_input_change();
    xfer(5'd9, 4'b0001, 32'h0000_0001, r, lat);
    xfer(5'd9, 4'h0, 32'h0, r, lat);
    n_checks++; if (r !== 32'h1) begin n_fail++; $display("FAIL irqen_read got %h exp 1", r); end
    @(negedge clk);
    i_regs[7:0] = 8'h3C;
    bus.mmi_valid = 1'b1; bus.i_mmi_addr = 5'd4; bus.mmi_wstrb = 4'h0;
    @(negedge clk);
    n_checks++; if (bus.mmi_ready !== 1'b1 || bus.o_mmi_rdata !== 32'h0) begin n_fail++; $display("FAIL in_early got rdy %0b data %h exp 1/0", bus.mmi_ready, bus.o_mmi_rdata); end
    bus.mmi_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (o_irq !== 1'b0) begin n_fail++; $display("FAIL irq_early got %0b exp 0", o_irq); end
    bus.mmi_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.mmi_ready !== 1'b1 || bus.o_mmi_rdata !== 32'h3C) begin n_fail++; $display("FAIL in_read got rdy %0b data %h exp 1/3c", bus.mmi_ready, bus.o_mmi_rdata); end
    n_checks++; if (o_irq !== 1'b1) begin n_fail++; $display("FAIL irq_set got %0b exp 1", o_irq); end
    bus.mmi_valid = 1'b0;
    xfer(5'd8, 4'h0, 32'h0, r, lat);
    n_checks++; if (r !== 32'h1) begin n_fail++; $display("FAIL chg_read got %h exp 1", r); end
  endtask

  task automatic test_w1c();
    @(negedge clk);
    i_regs[7:0] = 8'h3D;
    @(negedge clk);
    bus.mmi_valid = 1'b1; bus.i_mmi_addr = 5'd8; bus.mmi_wstrb = 4'b0001; bus.i_mmi_wdata = 32'h1;
    @(negedge clk);
    n_checks++; if (bus.mmi_ready !== 1'b1) begin n_fail++; $display("FAIL race_ready got %0b exp 1", bus.mmi_ready); end
    bus.mmi_valid = 1'b0; bus.mmi_wstrb = 4'h0;
    xfer(5'd8, 4'h0, 32'h0, r, lat);
    n_checks++; if (r !== 32'h1) begin n_fail++; $display("FAIL race_flag got %h exp 1", r); end
    n_checks++; if (o_irq !== 1'b1) begin n_fail++; $display("FAIL race_irq got %0b exp 1", o_irq); end
    xfer(5'd8, 4'b0001, 32'h1, r, lat);
    n_checks++; if (o_irq !== 1'b1) begin n_fail++; $display("FAIL w1c_irq_hold got %0b exp 1", o_irq); end
    @(negedge clk);
    n_checks++; if (o_irq !== 1'b0) begin n_fail++; $display("FAIL w1c_irq_clear got %0b exp 0", o_irq); end
    xfer(5'd8, 4'h0, 32'h0, r, lat);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL w1c_flag got %h exp 0", r); end
  endtask

  task automatic test_reset_mid();
    xfer(5'd1, 4'hF, 32'h1122_3344, r, lat);
    n_checks++; if (o_regs[63:32] !== 32'h1122_3344) begin n_fail++; $display("FAIL word1_write got %h exp 11223344", o_regs[63:32]); end
    @(negedge clk);
    bus.mmi_valid = 1'b1; bus.i_mmi_addr = 5'h1F; bus.mmi_wstrb = 4'hF; bus.i_mmi_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    n_checks++; if (bus.mmi_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready got %0b exp 1", bus.mmi_ready); end
    rst = 1'b0;
    #1;
    n_checks++; if (bus.mmi_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready_drop got %0b exp 0", bus.mmi_ready); end
    n_checks++; if (o_regs !== 128'h0) begin n_fail++; $display("FAIL mid_oregs got %h exp 0", o_regs); end
    bus.mmi_valid = 1'b0; bus.mmi_wstrb = 4'h0;
    @(negedge clk);
    rst = 1'b1;
    xfer(5'h1F, 4'h0, 32'h0, r, lat);
    n_checks++; if (r !== 32'h0 || lat !== 1) begin n_fail++; $display("FAIL unmapped_read got %h lat %0d exp 0/1", r, lat); end
    xfer(5'h1F, 4'hF, 32'hFFFF_FFFF, r, lat);
    n_checks++; if (o_regs !== 128'h0 || lat !== 1) begin n_fail++; $display("FAIL unmapped_write got %h lat %0d exp 0/1", o_regs, lat); end
    xfer(5'd10, 4'hF, 32'hFFFF_FFFF, r, lat);
    xfer(5'd10, 4'h0, 32'h0, r, lat);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL addr10_read got %h exp 0", r); end
    xfer(5'd1, 4'h0, 32'h0, r, lat);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL word1_after_rst got %h exp 0", r); end
    xfer(5'd9, 4'h0, 32'h0, r, lat);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL irqen_after_rst got %h exp 0", r); end
  endtask

  initial begin
    bus.mmi_valid = 1'b0; bus.mmi_wstrb = 4'h0; bus.i_mmi_wdata = 32'h0; bus.i_mmi_addr = 5'h0;
    i_regs = '0;
    test_reset();
    test_partial_write();
    test_back_to_back();
    test_pulse();
    test_input_change();
    test_w1c();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmi_regbank.md
Name: mmi_regbank

Overview:
- Parametrised memory-mapped register bank; next generation of the fixed-layout MMI RAM.
- Sits between the CPU valid/ready RAM-bus and any coprocessor (COM, CRC, CP).
- Provides NUM_OUT byte-wide output registers and NUM_IN byte-wide sampled input registers, packed 4 per 32-bit word.
- New features: per-byte self-clearing pulse outputs, input change detection with sticky W1C flags, and a maskable interrupt.

Parameters:
- NUM_OUT, 16, number of output byte registers (1..64).
- NUM_IN, 16, number of input byte registers (1..32).
- ADDR_W, 5, word-address width; requires OUT_WORDS+IN_WORDS+2 <= 2^ADDR_W.
- PULSE_MASK, 0 (NUM_OUT bits), bit k=1 makes output byte k self-clearing.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- mmi_valid  in  1  bus request.
- mmi_ready  out  1  bus acknowledge, registered.
- mmi_wstrb  in  4  byte write strobes; 0 = read.
- i_mmi_wdata  in  32  write data.
- o_mmi_rdata  out  32  read data, valid while mmi_ready=1.
- i_mmi_addr  in  ADDR_W  word address.
- i_regs  in  NUM_IN*8  coprocessor status/data bytes; byte j = bits [8j+7:8j].
- o_regs  out  NUM_OUT*8  coprocessor control bytes; byte k = bits [8k+7:8k].
- o_irq  out  1  level interrupt.

Behaviour:
- Derived values: OUT_WORDS=ceil(NUM_OUT/4), IN_WORDS=ceil(NUM_IN/4).
- Word map:
  - 0..OUT_WORDS-1: output regs, RW.
  - OUT_WORDS..OUT_WORDS+IN_WORDS-1: input samples, RO.
  - next word: CHG_FLAGS, W1C.
  - next word: IRQ_EN, RW.
  - All other addresses: read 0, writes ignored, ready still returned (no hang).
  - Bytes beyond NUM_OUT/NUM_IN read 0 and are not writable.
- Reset (rst=0, async): mmi_ready=0, o_mmi_rdata=0, o_regs=0, in_q=0, prev=0, CHG_FLAGS=0, IRQ_EN=0, o_irq=0, FSM=IDLE.
  - Reset mid-transaction abandons it; no partial write commits after release.
- FSM states: IDLE, RESP.
  - IDLE, mmi_valid=1 at edge: capture o_mmi_rdata (pre-write contents), commit writes to strobed bytes, go to RESP.
  - RESP: mmi_ready=1 for exactly one cycle; the next edge returns to IDLE regardless of mmi_valid.
  - Latency: ready asserts one cycle after valid is first sampled. Maximum rate is one transfer per 2 cycles.
  - Master must hold addr/wdata/wstrb stable until ready. o_mmi_rdata returns to 0 in IDLE.
- Writes: each byte is written only where its wstrb bit = 1; partial strobes are legal.
- Pulse bytes (PULSE_MASK[k]=1):
  - Written value appears on o_regs for exactly one cycle (the RESP cycle), then clears to 0.
  - Reads of a pulse byte return 0 except in the cycle the write lands.
- Input sampling:
  - in_q <= i_regs every cycle; prev <= in_q.
  - CHG_FLAGS[j] sets when in_q byte j != prev byte j.
  - Writing 1 clears the flag. Simultaneous set and clear: set wins.
- Interrupt: o_irq registered = |(CHG_FLAGS & IRQ_EN), one cycle after the flag update.
- Input read latency: a value on i_regs becomes readable 1 cycle later; its flag sets 2 cycles later.

Decomposition:
- Package mmi_regbank_pkg holds:
  - state enum {IDLE, RESP};
  - functions for OUT_WORDS/IN_WORDS and the CHG_FLAGS/IRQ_EN word indices;
  - a byte-lane strobe-merge function.
- One sub-module, mmi_in_tracker (parametrised on NUM_IN): sampling register, prev register, change flags with W1C port, IRQ AND-reduce.

Test Plan:
- Reset then read every mapped word -> all return 0, o_irq=0; ready asserts exactly 1 cycle after valid each time.
- Write word 0 = 0xA5A5_1234 with wstrb=4'b0101 -> o_regs[31:0]=0x00A5_0034; readback gives same value, 2-cycle transfer.
- PULSE_MASK bit 1 set, write byte1=0x7E -> o_regs[15:8]=0x7E for exactly one cycle, then 0x00; other bytes unchanged.
- i_regs byte 0 changes 0x00->0x3C with IRQ_EN bit0=1 -> input word reads 0x3C after 1 cycle; CHG_FLAGS bit0=1 after 2 cycles; o_irq=1 after 3 cycles.
- W1C of bit0 in the same cycle as a new input change 0x3C->0x3D -> flag stays 1. Plain W1C without a change -> flag 0 and o_irq 0 next cycle.
- Assert rst in the RESP cycle and access an unmapped address (e.g. 0x1F) -> ready drops immediately and o_regs=0; after release, the unmapped read returns 0 with ready, and an unmapped write changes nothing.
